// File: rtl/memory_bus_responder_if.sv
// ============================================================================
// Module      : memory_bus_responder_if
// Description : Core memory bus bundle shared by an initiator (core) and the
//               target-side responder.
//               master : drives memory_read/memory_write/address/write_data,
//                        observes read_data/memory_response/error/busy
//               slave  : the mirror image
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_bus_responder_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 memory_read;
  logic                 memory_write;
  logic [BUS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0] write_data;
  logic [BUS_WIDTH-1:0] read_data;
  logic                 memory_response;
  logic                 error;
  logic                 busy;

  modport master (
    output memory_read, memory_write, address, write_data,
    input  read_data, memory_response, error, busy
  );

  modport slave (
    input  memory_read, memory_write, address, write_data,
    output read_data, memory_response, error, busy
  );
endinterface

`default_nettype wire

// File: rtl/memory_bus_responder.sv
// ============================================================================
// Module      : memory_bus_responder
// Description : Target-side end of the core memory bus. Backs a word-addressed
//               RAM, answers each read/write request after a programmable
//               number of cycles with a one-cycle memory_response pulse, and
//               rejects out-of-range or read+write conflicting requests.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-low reset
//               bus   - memory bus, slave side (request in, response out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_bus_responder #(
  parameter int    BUS_WIDTH     = 32,
  parameter int    WORD_SIZE_BY  = 4,
  parameter int    MEMORY_SIZE   = 4096,
  parameter int    READ_LATENCY  = 2,
  parameter int    WRITE_LATENCY = 1,
  parameter string MEMORY_FILE   = ""
) (
  input logic                   clk,
  input logic                   reset,
  memory_bus_responder_if.slave bus
);

  localparam int c_AW     = $clog2(MEMORY_SIZE);
  localparam int c_OFF    = $clog2(WORD_SIZE_BY);
  localparam int c_DEPTH  = MEMORY_SIZE / WORD_SIZE_BY;
  localparam int c_IW     = c_AW - c_OFF;
  localparam int c_MAXLAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  // Counter only ever holds LAT-1, which fits in clog2(LAT) bits.
  localparam int c_CW     = (c_MAXLAT < 2) ? 1 : $clog2(c_MAXLAT);

  localparam logic [c_CW-1:0] c_RD_LOAD  = c_CW'(READ_LATENCY - 1);
  localparam logic [c_CW-1:0] c_WR_LOAD  = c_CW'(WRITE_LATENCY - 1);
  localparam logic [c_CW-1:0] c_ERR_LOAD = '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  logic [BUS_WIDTH-1:0] r_mem [c_DEPTH];

  state_t               r_state;
  logic [c_CW-1:0]      r_cnt;
  logic [c_IW-1:0]      r_idx;
  logic [BUS_WIDTH-1:0] r_wdata;
  logic                 r_wr;
  logic                 r_err;
  logic                 r_resp;
  logic                 r_error;
  logic                 r_busy;
  logic [BUS_WIDTH-1:0] r_rdata;

  logic            w_req;
  logic            w_oor;
  logic            w_err;
  logic            w_accept;
  logic            w_done;
  logic            w_ram_we;
  logic [c_CW-1:0] w_load;
  logic            w_unused_addr;

  assign w_req  = bus.memory_read | bus.memory_write;
  // Any address bit at or above log2(MEMORY_SIZE) puts the request off the end of the RAM.
  assign w_oor  = |bus.address[BUS_WIDTH-1:c_AW];
  assign w_err  = (bus.memory_read & bus.memory_write) | w_oor;
  // RESPOND behaves like IDLE for sampling, so a held request restarts immediately.
  assign w_accept = w_req && ((r_state == S_IDLE) || (r_state == S_RESPOND));
  // Last WAIT cycle: the next edge is the RESPOND entry edge.
  assign w_done   = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_ram_we = w_done && r_wr && !r_err;
  // Byte-within-word bits are deliberately ignored (word-aligned access).
  assign w_unused_addr = &{1'b0, bus.address[c_OFF-1:0]};

  always_comb begin
    w_load = c_RD_LOAD;
    if (w_err) begin
      w_load = c_ERR_LOAD;
    end else if (bus.memory_write) begin
      w_load = c_WR_LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_resp  <= 1'b0;
      r_error <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_resp  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE, S_RESPOND: begin
          if (w_accept) begin
            r_idx   <= bus.address[c_AW-1:c_OFF];
            r_wdata <= bus.write_data;
            r_wr    <= bus.memory_write;
            r_err   <= w_err;
            r_cnt   <= w_load;
            r_state <= S_WAIT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_RESPOND;
            r_resp  <= 1'b1;
            r_error <= r_err;
            if (r_err) begin
              r_rdata <= '0;
            end else if (!r_wr) begin
              r_rdata <= r_mem[r_idx];
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM has no reset: contents survive reset, and an aborted write never
  // reaches w_ram_we because reset forces the FSM back to IDLE.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign bus.read_data       = r_rdata;
  assign bus.memory_response = r_resp;
  assign bus.error           = r_error;
  assign bus.busy            = r_busy;

endmodule

`default_nettype wire
